// File: rtl/dense_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_seq
// Brief    : Streaming fully connected layer. One input element is accepted per
//            handshake, a bias and saturation stage follows, ReLU is optional,
//            and one neuron result is emitted per handshake.
// Revision : 1.0  initial release
// ============================================================================
module dense_layer_seq #(
    parameter int INPUT_SIZE  = 4,
    parameter int OUTPUT_SIZE = 3,
    parameter int WIDTH       = 16,
    parameter int FRAC        = 8,
    localparam int c_ROW_W    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
    localparam int c_COL_W    = $clog2(INPUT_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic               cfg_bias,
    input  logic [c_ROW_W-1:0] cfg_row,
    input  logic [c_COL_W-1:0] cfg_col,
    input  logic [WIDTH-1:0]   cfg_data,
    input  logic               relu_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [c_ROW_W-1:0] out_idx,
    output logic               out_last,
    output logic               busy
);

    localparam int c_ACC_W = 2 * WIDTH + c_COL_W;
    localparam int c_SUM_W = c_ACC_W + 1;

    localparam logic [1:0] c_ACCUM  = 2'd0;
    localparam logic [1:0] c_FINISH = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;

    localparam logic [c_COL_W-1:0] c_IN_LAST  = c_COL_W'(INPUT_SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_OUT_LAST = c_ROW_W'(OUTPUT_SIZE - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [c_COL_W-1:0]        r_in_cnt;
    logic [c_ROW_W-1:0]        r_out_cnt;
    logic                      r_relu;

    logic signed [WIDTH-1:0]   r_weight [OUTPUT_SIZE][INPUT_SIZE];
    logic signed [WIDTH-1:0]   r_bias   [OUTPUT_SIZE];
    logic signed [c_ACC_W-1:0] r_acc    [OUTPUT_SIZE];
    logic signed [WIDTH-1:0]   r_res    [OUTPUT_SIZE];

    logic signed [c_ACC_W-1:0] w_acc_nxt [OUTPUT_SIZE];
    logic signed [WIDTH-1:0]   w_res     [OUTPUT_SIZE];

    logic w_in_acc;
    logic w_out_hs;
    logic w_in_last;
    logic w_out_last;
    logic w_cfg_wr;

    assign in_ready   = (r_state == c_ACCUM);
    assign out_valid  = (r_state == c_DRAIN);
    assign w_in_acc   = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_in_last  = (r_in_cnt == c_IN_LAST);
    assign w_out_last = (r_out_cnt == c_OUT_LAST);

    // busy covers the element-0 accept cycle itself so a coincident cfg write is dropped
    assign busy = (r_state != c_ACCUM) || (r_in_cnt != '0) || w_in_acc;

    assign w_cfg_wr = cfg_we && !busy && (cfg_row <= c_OUT_LAST)
                      && (cfg_bias || (cfg_col <= c_IN_LAST));

    assign out_data = r_res[r_out_cnt];
    assign out_idx  = r_out_cnt;
    assign out_last = out_valid && w_out_last;

    generate
        for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_neuron
            logic signed [2*WIDTH-1:0] w_prod;
            logic signed [c_SUM_W-1:0] w_acc_ext;
            logic signed [c_SUM_W-1:0] w_bias_ext;
            logic signed [c_SUM_W-1:0] w_sum;
            logic signed [c_SUM_W-1:0] w_shift;
            logic [c_SUM_W-WIDTH:0]    w_hi;
            logic                      w_ovf;
            logic signed [WIDTH-1:0]   w_sat;

            assign w_prod = r_weight[j][r_in_cnt] * $signed(in_data);

            // element 0 restarts the sum instead of adding to the previous frame
            assign w_acc_nxt[j] = ((r_in_cnt == '0) ? '0 : r_acc[j])
                                  + {{(c_ACC_W - 2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};

            assign w_acc_ext  = {r_acc[j][c_ACC_W-1], r_acc[j]};
            assign w_bias_ext = {{(c_SUM_W - WIDTH){r_bias[j][WIDTH-1]}}, r_bias[j]};
            assign w_sum      = w_acc_ext + (w_bias_ext <<< FRAC);
            assign w_shift    = w_sum >>> FRAC;

            // the value fits only when all bits above the output sign bit agree with it
            assign w_hi  = w_shift[c_SUM_W-1:WIDTH-1];
            assign w_ovf = !((&w_hi) || !(|w_hi));
            assign w_sat = !w_ovf ? w_shift[WIDTH-1:0]
                         : (w_shift[c_SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}});

            assign w_res[j] = (r_relu && w_sat[WIDTH-1]) ? '0 : w_sat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ACCUM:  if (w_in_acc && w_in_last) w_state_nxt = c_FINISH;
            c_FINISH: w_state_nxt = c_DRAIN;
            c_DRAIN:  if (w_out_hs && w_out_last) w_state_nxt = c_ACCUM;
            default:  w_state_nxt = c_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_relu    <= 1'b0;
        end else begin
            if (w_in_acc) begin
                r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
                if (r_in_cnt == '0) r_relu <= relu_en;
            end
            if (w_out_hs) begin
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                r_acc[j]  <= '0;
                r_res[j]  <= '0;
                r_bias[j] <= '0;
                for (int k = 0; k < INPUT_SIZE; k++) begin
                    r_weight[j][k] <= '0;
                end
            end
        end else begin
            if (w_cfg_wr) begin
                if (cfg_bias) r_bias[cfg_row] <= cfg_data;
                else          r_weight[cfg_row][cfg_col] <= cfg_data;
            end
            if (w_in_acc) begin
                for (int j = 0; j < OUTPUT_SIZE; j++) r_acc[j] <= w_acc_nxt[j];
            end
            if (r_state == c_FINISH) begin
                for (int j = 0; j < OUTPUT_SIZE; j++) r_res[j] <= w_res[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_layer_seq
// Brief    : Scoreboard bench for dense_layer_seq with directed frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_dense_layer_seq;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_bias = 1'b0;
    logic [1:0]  cfg_row = '0;
    logic [1:0]  cfg_col = '0;
    logic [15:0] cfg_data = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   lat_arm = 0;
    bit   stall_en = 0;
    int   stall_cnt = 0;
    exp_t exp_q [$];

    dense_layer_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_bias (cfg_bias),
        .cfg_row  (cfg_row),
        .cfg_col  (cfg_col),
        .cfg_data (cfg_data),
        .relu_en  (relu_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void push3(logic [15:0] a, logic [15:0] b, logic [15:0] c);
        exp_q.push_back('{a, 2'd0, 1'b0});
        exp_q.push_back('{b, 2'd1, 1'b0});
        exp_q.push_back('{c, 2'd2, 1'b1});
    endfunction

    // Monitor: pops the scoreboard on every output handshake, checks stall hold.
    initial begin
        exp_t        e;
        bit          prev_stall = 0;
        logic [15:0] held_data = '0;
        logic [1:0]  held_idx = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                check("in_ready_in_drain", in_ready, 0);
                if (lat_arm) begin
                    check("first_valid_latency", cyc - acc_cyc, 2);
                    lat_arm = 0;
                end
                if (prev_stall) begin
                    check("stall_hold_data", out_data, held_data);
                    check("stall_hold_idx", out_idx, held_idx);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                    end
                end
                prev_stall = !out_ready;
                held_data  = out_data;
                held_idx   = out_idx;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Output back-pressure: three stall cycles while idx 1 is presented.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en && out_valid && out_idx == 2'd1 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                if (!out_valid) stall_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg(input logic b, input logic [1:0] row, input logic [1:0] col,
                       input logic [15:0] data);
        cfg_we = 1'b1; cfg_bias = b; cfg_row = row; cfg_col = col; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_all_w(input logic [15:0] v);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++) cfg(1'b0, 2'(j), 2'(k), v);
    endtask

    task automatic set_all_b(input logic [15:0] v);
        for (int j = 0; j < 3; j++) cfg(1'b1, 2'(j), 2'd0, v);
    endtask

    task automatic set_diag(input logic [15:0] v);
        for (int j = 0; j < 3; j++) cfg(1'b0, 2'(j), 2'(j), v);
    endtask

    task automatic send_frame(input logic [15:0] din [4], input logic rf, input logic rr,
                              input bit bub, input int lock_k, input int n, input bit lat);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            if (bub) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data  = din[k];
            relu_en  = (k == 0) ? rf : rr;
            if (k == lock_k) begin
                cfg_we = 1'b1; cfg_bias = 1'b0; cfg_row = 2'd0; cfg_col = 2'd0;
                cfg_data = 16'h0500;
            end
            while (!in_ready && g < 40) begin tick(); g++; end
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            if (k == 3 && lat) begin acc_cyc = cyc; lat_arm = 1; end
            tick();
            cfg_we = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 60) begin tick(); g++; end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
        check("busy_idle", busy, 0);
        check("in_ready_idle", in_ready, 1);
    endtask

    initial begin
        logic [15:0] id  [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        logic [15:0] big [4] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        logic [15:0] neg [4] = '{16'hFFFF, 16'h1234, 16'h0100, 16'h8000};

        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // identity
        set_diag(16'h0100);
        push3(16'h0100, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 0, -1, 4, 1);
        wait_drain();

        // bias -1.0 with and without ReLU, relu_en toggled mid-frame
        set_all_w(16'h0000);
        set_all_b(16'hFF00);
        push3(16'hFF00, 16'hFF00, 16'hFF00);
        send_frame(id, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();
        push3(16'h0000, 16'h0000, 16'h0000);
        send_frame(id, 1'b1, 1'b1, 0, -1, 4, 0);
        wait_drain();
        push3(16'h0000, 16'h0000, 16'h0000);
        send_frame(id, 1'b1, 1'b0, 0, -1, 4, 0);
        wait_drain();
        push3(16'hFF00, 16'hFF00, 16'hFF00);
        send_frame(id, 1'b0, 1'b1, 0, -1, 4, 0);
        wait_drain();

        // saturation both ways
        set_all_b(16'h0000);
        set_all_w(16'h7F00);
        push3(16'h7FFF, 16'h7FFF, 16'h7FFF);
        send_frame(big, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();
        set_all_w(16'h8000);
        push3(16'h8000, 16'h8000, 16'h8000);
        send_frame(big, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();

        // floor of 0.5 * -1 LSB
        set_all_w(16'h0000);
        cfg(1'b0, 2'd0, 2'd0, 16'h0080);
        push3(16'hFFFF, 16'h0000, 16'h0000);
        send_frame(neg, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();

        // handshake stress
        set_all_w(16'h0000);
        set_diag(16'h0100);
        stall_en = 1;
        push3(16'h0100, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 1, -1, 4, 0);
        wait_drain();
        stall_en = 0;

        // config lockout: mid-frame write and element-0 coincident write both dropped
        push3(16'h0100, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 0, 1, 4, 0);
        wait_drain();
        push3(16'h0100, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 0, 0, 4, 0);
        wait_drain();
        cfg(1'b0, 2'd0, 2'd0, 16'h0500);
        push3(16'h0500, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();

        // asynchronous reset after two inputs
        send_frame(id, 1'b0, 1'b0, 0, -1, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push3(16'h0000, 16'h0000, 16'h0000);
        send_frame(id, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();
        set_diag(16'h0100);
        push3(16'h0100, 16'h0200, 16'h0300);
        send_frame(id, 1'b0, 1'b0, 0, -1, 4, 0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dense_layer_seq.md
# dense_layer_seq

Sequential, parametrised fully connected layer: OUTPUT_SIZE neurons over INPUT_SIZE signed fixed-point inputs, with bias, saturation and selectable ReLU. It is the clocked successor of the combinational per-neuron weighted-sum layer. Inputs stream in one element per handshake, all neuron accumulators update in parallel, and results stream out one neuron per handshake. Weights and biases sit in internal registers loaded through a write port, so neuron count and input count are free parameters.

## Interface
- INPUT_SIZE, 4: number of input elements per frame (≥2).
- OUTPUT_SIZE, 3: number of neurons (≥1).
- WIDTH, 16: signed two's-complement data, weight, bias and output width.
- FRAC, 8: fractional bits of the Q format shared by all operands.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  weight/bias write strobe.
- cfg_bias  in  1  1 = write bias[cfg_row]; 0 = write weight[cfg_row][cfg_col].
- cfg_row  in  clog2(OUTPUT_SIZE)  neuron index.
- cfg_col  in  clog2(INPUT_SIZE)  input index; ignored for bias writes.
- cfg_data  in  WIDTH  value written.
- relu_en  in  1  activation mode; sampled on the first input accept of a frame.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  WIDTH  input element, in index order 0..INPUT_SIZE-1.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  WIDTH  neuron result.
- out_idx  out  clog2(OUTPUT_SIZE)  neuron index of out_data.
- out_last  out  1  high with the OUTPUT_SIZE-1 result.
- busy  out  1  high from the first input accept until the last output handshake.

## Operation
- States: ACCUM, FINISH, DRAIN.
- ACCUM: in_ready=1. On each accept of element k, every neuron j updates acc[j] += w[j][k]*in_data. Products are full 2*WIDTH signed. The accumulator is ACC_W = 2*WIDTH + clog2(INPUT_SIZE) bits and cannot overflow. Accepting element 0 clears all acc before the add and latches relu_en. Accepting element INPUT_SIZE-1 moves the FSM to FINISH.
- FINISH (1 cycle, in_ready=0): for each j, form t = (acc[j] + (sext(bias[j]) << FRAC)) >>> FRAC, using an arithmetic shift that truncates toward minus infinity.
  - Saturate t to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If the latched relu_en is set, replace negative results with 0.
  - Store into res[j]. Go to DRAIN.
- DRAIN: out_valid=1, out_data=res[n], out_idx=n, out_last=(n==OUTPUT_SIZE-1).
  - n advances on each out_valid&&out_ready.
  - The handshake with out_last returns the FSM to ACCUM with n=0, and busy falls.
- Input bubbles (in_valid=0) are allowed at any point in ACCUM. The element counter holds.
- cfg writes take effect the next cycle only while busy=0. Writes while busy=1 are dropped.
- Register contents after reset: weights and biases are 0.

## Timing
- Reset values:
  - FSM=ACCUM, counters=0, acc=0, res=0.
  - in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
  - All weights and biases = 0.
- Reset mid-frame: all partial sums and pending results are discarded. The next accepted input is element 0.
- Latency: the last input accept at cycle c produces the FINISH register update at c+1 and out_valid=1 at c+2.
- Minimum frame period: INPUT_SIZE + 1 + OUTPUT_SIZE cycles.
- Outputs are registered. While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- in_ready is 0 in FINISH and DRAIN. There is no overlap of consecutive frames.
- Counter wrap: the input counter wraps INPUT_SIZE-1 → 0 and the output counter wraps OUTPUT_SIZE-1 → 0, each exactly on its final handshake.
- busy rises combinationally with the element-0 accept. A cfg_we in that same cycle is dropped.

## Test plan
All scenarios use the default parameters; 1.0 = 0x0100.
- Identity: set w[j][j]=0x0100, all other weights 0, bias 0, relu_en=0. Stream 0x0100, 0x0200, 0x0300, 0x0400 back-to-back -> outputs 0x0100, 0x0200, 0x0300 with idx 0, 1, 2. out_last is on idx 2. The first out_valid appears 2 cycles after the last input accept.
- Bias and ReLU:
  - All weights 0, bias = 0xFF00 (-1.0). Frame with relu_en=0 -> all outputs 0xFF00.
  - Repeat with relu_en=1 -> all outputs 0x0000.
  - Toggling relu_en mid-frame has no effect.
- Saturation and rounding:
  - All weights 0x7F00, inputs 0x7F00 -> all outputs 0x7FFF.
  - Weights 0x8000, inputs 0x7F00 -> all outputs 0x8000.
  - Weight 0x0080 (0.5) on w[0][0] only, input 0xFFFF (-1 LSB) -> output 0 = 0xFFFF (floor).
- Handshake stress: random in_valid bubbles, and out_ready low for 3 cycles on idx 1 -> identical results to the identity case, with out_data and out_idx held while stalled. in_ready stays 0 until after out_last.
- Config lockout: cfg_we writes weight 0x0500 while busy=1 -> the current and next frames use the old weight. The same write while busy=0 -> the next frame uses 0x0500.
- Reset mid-frame: assert rst_n=0 after 2 inputs (async, between edges) -> outputs read 0 immediately, in_ready=1, weights read 0. A new full frame after reloading the config produces the correct results.
